regfile_writeback_queue: RTL

- Buffers register-file write requests from the execute/memory stages in a small FIFO.
- Issues them to the register file input decoder as dual-slot byte/word write commands.
- When the feature is compiled in, pairs two independent single-byte writes into one issue cycle.
- Sits directly upstream of the input decoder. Its outputs drive the decoder's wr_en, data_in and wr_addr.

---
 rtl/regfile_writeback_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// Register-file writeback queue: buffers byte/word write requests and issues them as
// dual-slot commands to the input decoder. Define WB_PAIR_EN to pair independent byte writes.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_reg,
  input  logic [1:0]       req_byte_en,
  input  logic [15:0]      req_data,
  input  logic             wb_hold,
  input  logic             wb_flush,
  output logic [1:0]       wr_en,
  output logic [9:0]       wr_addr,
  output logic [15:0]      data_out,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [3:0]  rg;
    logic [1:0]  be;
    logic [15:0] data;
  } wb_req_t;

  wb_req_t          mem [DEPTH];
  wb_req_t          head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push;
  logic [1:0]       pop_n;
  logic [1:0]       nx_en;
  logic [9:0]       nx_addr;
  logic [15:0]      nx_data;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign req_ready = (count < DEPTH_C);
  assign push      = req_valid && req_ready && !wb_flush;
  assign head      = mem[rd_ptr];

`ifdef WB_PAIR_EN
  logic [PTR_W-1:0] rd_ptr_nx1;
  logic             sec_byte, pair_ok;
  assign rd_ptr_nx1 = rd_ptr + 1'b1;
  assign sec_byte   = (mem[rd_ptr_nx1].be == 2'b01) || (mem[rd_ptr_nx1].be == 2'b10);
  // Same reg and same byte must stay ordered; same reg with different bytes may share a cycle.
  assign pair_ok    = sec_byte && (count >= CNT_W'(2)) &&
                      !((mem[rd_ptr_nx1].rg == head.rg) && (mem[rd_ptr_nx1].be == head.be));
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{rg: req_reg, be: req_byte_en, data: req_data};
  end

  always_comb begin
    pop_n   = 2'd0;
    nx_en   = 2'b00;
    nx_addr = '0;
    nx_data = '0;
    if (!wb_hold && (count != '0)) begin
      case (head.be)
        2'b11: begin
          pop_n   = 2'd1;
          nx_en   = 2'b11;
          nx_addr = {1'b1, head.rg, 1'b0, head.rg};
          nx_data = head.data;
        end
        2'b01, 2'b10: begin
          pop_n         = 2'd1;
          nx_en         = 2'b01;
          nx_addr[4:0]  = {head.be[1], head.rg};
          nx_data[7:0]  = head.data[7:0];
`ifdef WB_PAIR_EN
          if (pair_ok) begin
            pop_n         = 2'd2;
            nx_en         = 2'b11;
            nx_addr[9:5]  = {mem[rd_ptr_nx1].be[1], mem[rd_ptr_nx1].rg};
            nx_data[15:8] = mem[rd_ptr_nx1].data[7:0];
          end
`endif
        end
        // Null entries are discarded but still consume the issue slot.
        default: pop_n = 2'd1;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_en    <= 2'b00;
      wr_addr  <= '0;
      data_out <= '0;
    end else if (wb_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_en    <= 2'b00;
      wr_addr  <= '0;
      data_out <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(push);
      rd_ptr   <= rd_ptr + PTR_W'(pop_n);
      count    <= count + CNT_W'(push) - CNT_W'(pop_n);
      wr_en    <= nx_en;
      wr_addr  <= nx_addr;
      data_out <= nx_data;
    end
  end

endmodule
